// File: rtl/reg_wb_writer.sv
// Register-file writeback queue: buffers accepted writes in order, drains one per
// cycle onto the register-file write port, and forwards pending data to two read lookups.
module reg_wb_writer #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    WB_valid,
  input  logic [AW-1:0]           WB_addr,
  input  logic [DW-1:0]           WB_data,
  output logic                    WB_ready,
  input  logic                    RF_busy,
  output logic                    REG_write_1,
  output logic [AW-1:0]           REG_address_wr,
  output logic [DW-1:0]           REG_data_wr_in1,
  input  logic [AW-1:0]           RD_addr1,
  input  logic [AW-1:0]           RD_addr2,
  output logic                    FWD_hit1,
  output logic                    FWD_hit2,
  output logic [DW-1:0]           FWD_data1,
  output logic [DW-1:0]           FWD_data2,
  output logic [$clog2(DEPTH):0]  WB_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] q_addr_q [DEPTH];
  logic [DW-1:0] q_data_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic push;
  logic pop;

  // Ready depends only on the registered count, so a pop cannot open a slot in the same cycle.
  assign WB_ready = (count_q != CW'(DEPTH));
  assign pop      = !RF_busy && (count_q != '0);
  assign push     = WB_valid && WB_ready && (WB_addr != '0);

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wr_en_d   = pop;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      wr_addr_d = q_addr_q[rd_ptr_q];
      wr_data_d = q_data_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Entry contents need no reset: the count alone says which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr_q[wr_ptr_q] <= WB_addr;
      q_data_q[wr_ptr_q] <= WB_data;
    end
  end

  assign REG_write_1     = wr_en_q;
  assign REG_address_wr  = wr_addr_q;
  assign REG_data_wr_in1 = wr_data_q;
  assign WB_count        = count_q;

  logic [2*AW-1:0] rd_addr_vec;
  logic [1:0]      fwd_hit_vec;
  logic [2*DW-1:0] fwd_data_vec;

  assign rd_addr_vec = {RD_addr2, RD_addr1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [AW-1:0] look;
      logic          hit;
      logic [DW-1:0] data;

      assign look = rd_addr_vec[gi*AW +: AW];

      // Scan oldest to newest so the last match left standing is the newest write.
      always_comb begin
        hit  = 1'b0;
        data = '0;
        if (look != '0) begin
          if (wr_en_q && (wr_addr_q == look)) begin
            hit  = 1'b1;
            data = wr_data_q;
          end
          for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (q_addr_q[rd_ptr_q + PW'(i)] == look)) begin
              hit  = 1'b1;
              data = q_data_q[rd_ptr_q + PW'(i)];
            end
          end
        end
      end

      assign fwd_hit_vec[gi]           = hit;
      assign fwd_data_vec[gi*DW +: DW] = data;
    end
  endgenerate

  assign FWD_hit1  = fwd_hit_vec[0];
  assign FWD_hit2  = fwd_hit_vec[1];
  assign FWD_data1 = fwd_data_vec[DW-1:0];
  assign FWD_data2 = fwd_data_vec[2*DW-1:DW];

endmodule
